// File: rtl/dds_lut_loader.sv
// dds_lut_loader: ping-pong refill engine for the DDS lookup RAM.
// Streams host samples into the RAM half the wave generator is not reading.
//
// Ports:
//   i_clk, i_reset        clock, async active-high reset
//   i_enable              loader active (0 returns to IDLE)
//   i_clear_err           pulse, clears o_underrun
//   i_ram_isr             read-half indicator from wave generator
//   i_sample_data/valid   incoming sample stream
//   o_sample_ready        sample accepted this cycle
//   o_wr_en/address/data  registered RAM write port
//   o_half_req            1-cycle pulse when a new half fill starts
//   o_underrun            sticky: reader reached a half still being filled
module dds_lut_loader #(
    parameter int _RAM_ADD_WIDTH = 10,
    parameter int _RAM_DAT_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_clear_err,
    input  logic                      i_ram_isr,
    input  logic [_RAM_DAT_WIDTH-1:0] i_sample_data,
    input  logic                      i_sample_valid,
    output logic                      o_sample_ready,
    output logic                      o_wr_en,
    output logic [_RAM_ADD_WIDTH-1:0] o_wr_address,
    output logic [_RAM_DAT_WIDTH-1:0] o_wr_data,
    output logic                      o_half_req,
    output logic                      o_underrun
);

    localparam int CW = _RAM_ADD_WIDTH - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [CW-1:0] LAST = '1;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          wr_half;
    logic          isr_q;
    logic          isr_edge;
    logic          beat;
    logic          underrun_set;

    // Any toggle of the read-half flag means the reader moved halves.
    assign isr_edge = i_ram_isr ^ isr_q;

    assign o_sample_ready = (state == S_FILL) & i_enable;
    assign beat           = i_sample_valid & o_sample_ready;

    // While filling, the reader can only move into the half being written.
    assign underrun_set = (state == S_FILL) & i_enable & isr_edge;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            isr_q <= 1'b0;
        end else begin
            isr_q <= i_ram_isr;
        end
    end

    // Write port: the beat's address is captured from the pre-update
    // count, so a beat coinciding with a restart still lands correctly.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_wr_en      <= 1'b0;
            o_wr_address <= '0;
            o_wr_data    <= '0;
        end else begin
            o_wr_en <= beat;
            if (beat) begin
                o_wr_address <= {wr_half, count};
                o_wr_data    <= i_sample_data;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_underrun <= 1'b0;
        end else if (underrun_set) begin
            o_underrun <= 1'b1;
        end else if (i_clear_err) begin
            o_underrun <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            count      <= '0;
            wr_half    <= 1'b0;
            o_half_req <= 1'b0;
        end else begin
            o_half_req <= 1'b0;
            if (!i_enable) begin
                state <= S_IDLE;
                count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state      <= S_FILL;
                        wr_half    <= ~i_ram_isr;
                        count      <= '0;
                        o_half_req <= 1'b1;
                    end
                    S_FILL: begin
                        // Restart wins over completing the half.
                        if (isr_edge) begin
                            state      <= S_FILL;
                            wr_half    <= ~i_ram_isr;
                            count      <= '0;
                            o_half_req <= 1'b1;
                        end else if (beat) begin
                            count <= count + 1'b1;
                            if (count == LAST) begin
                                state <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (isr_edge) begin
                            state      <= S_FILL;
                            wr_half    <= ~i_ram_isr;
                            count      <= '0;
                            o_half_req <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_lut_loader.sv
// tb_dds_lut_loader: directed bench for dds_lut_loader (HALF = 8).
// Expected RAM writes are queued when a beat is driven and popped on write.
module tb_dds_lut_loader;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic          i_clear_err;
    logic          i_ram_isr;
    logic [DW-1:0] i_sample_data;
    logic          i_sample_valid;
    logic          o_sample_ready;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_address;
    logic [DW-1:0] o_wr_data;
    logic          o_half_req;
    logic          o_underrun;

    int n_assert = 0;
    int n_fail   = 0;
    int hreq_cnt = 0;
    int snap;

    logic [AW+DW-1:0] sb [$];

    dds_lut_loader #(
        ._RAM_ADD_WIDTH(AW),
        ._RAM_DAT_WIDTH(DW)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_clear_err   (i_clear_err),
        .i_ram_isr     (i_ram_isr),
        .i_sample_data (i_sample_data),
        .i_sample_valid(i_sample_valid),
        .o_sample_ready(o_sample_ready),
        .o_wr_en       (o_wr_en),
        .o_wr_address  (o_wr_address),
        .o_wr_data     (o_wr_data),
        .o_half_req    (o_half_req),
        .o_underrun    (o_underrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive one accepted sample and queue the write it must produce.
    task automatic beat(input logic [DW-1:0] d, input logic [AW-1:0] a);
        i_sample_valid = 1'b1;
        i_sample_data  = d;
        chk("ready_at_beat", {31'd0, o_sample_ready}, 32'd1);
        sb.push_back({a, d});
        tick();
    endtask

    // Write monitor: every strobe must match the oldest queued beat.
    always @(negedge i_clk) begin
        logic [AW+DW-1:0] e;
        if (!i_reset) begin
            if (o_half_req) hreq_cnt++;
            if (o_wr_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {28'd0, o_wr_address}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", {28'd0, o_wr_address}, {28'd0, e[AW+DW-1:DW]});
                    chk("wr_data", {16'd0, o_wr_data}, {16'd0, e[DW-1:0]});
                end
            end
        end
    end

    initial begin
        i_reset        = 1'b1;
        i_enable       = 1'b0;
        i_clear_err    = 1'b0;
        i_ram_isr      = 1'b0;
        i_sample_data  = '0;
        i_sample_valid = 1'b0;
        tick();
        tick();
        chk("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        chk("rst_ready", {31'd0, o_sample_ready}, 32'd0);

        // 1: reset in the middle of a fill
        i_reset  = 1'b0;
        i_enable = 1'b1;
        tick();
        chk("t1_hreq", {31'd0, o_half_req}, 32'd1);
        beat(16'h00A0, 4'd8);
        beat(16'h00A1, 4'd9);
        beat(16'h00A2, 4'd10);
        i_sample_valid = 1'b0;
        tick();
        i_reset = 1'b1;
        #1;
        chk("t1_addr0", {28'd0, o_wr_address}, 32'd0);
        chk("t1_data0", {16'd0, o_wr_data}, 32'd0);
        chk("t1_wren0", {31'd0, o_wr_en}, 32'd0);
        chk("t1_hreq0", {31'd0, o_half_req}, 32'd0);
        chk("t1_unrun0", {31'd0, o_underrun}, 32'd0);
        chk("t1_ready0", {31'd0, o_sample_ready}, 32'd0);
        tick();

        // 2: fill upper half with isr = 0
        i_reset = 1'b0;
        snap    = hreq_cnt;
        tick();
        chk("t2_hreq", {31'd0, o_half_req}, 32'd1);
        for (int i = 0; i < 8; i++) beat(16'h0100 + 16'(i), 4'(8 + i));
        i_sample_valid = 1'b0;
        chk("t2_wait_ready", {31'd0, o_sample_ready}, 32'd0);
        tick();
        tick();
        chk("t2_wait_ready2", {31'd0, o_sample_ready}, 32'd0);
        chk("t2_one_hreq", hreq_cnt - snap, 32'd1);

        // 3: reader moves to upper half, fill lower half
        i_ram_isr = 1'b1;
        tick();
        chk("t3_hreq", {31'd0, o_half_req}, 32'd1);
        chk("t3_ready", {31'd0, o_sample_ready}, 32'd1);
        for (int i = 0; i < 8; i++) beat(16'h0200 + 16'(i), 4'(i));
        i_sample_valid = 1'b0;
        tick();
        chk("t3_unrun", {31'd0, o_underrun}, 32'd0);
        chk("t3_wait_ready", {31'd0, o_sample_ready}, 32'd0);

        // 4: underrun while filling upper half at count 5
        i_ram_isr = 1'b0;
        tick();
        chk("t4_hreq", {31'd0, o_half_req}, 32'd1);
        for (int i = 0; i < 5; i++) beat(16'h0300 + 16'(i), 4'(8 + i));
        i_sample_valid = 1'b0;
        i_ram_isr      = 1'b1;
        tick();
        chk("t4_unrun", {31'd0, o_underrun}, 32'd1);
        chk("t4_restart_hreq", {31'd0, o_half_req}, 32'd1);
        chk("t4_ready", {31'd0, o_sample_ready}, 32'd1);
        for (int i = 0; i < 3; i++) beat(16'h0310 + 16'(i), 4'(i));
        i_sample_valid = 1'b0;
        i_clear_err    = 1'b1;
        tick();
        i_clear_err = 1'b0;
        chk("t4_clear", {31'd0, o_underrun}, 32'd0);

        // 5: toggling valid, enable drop at count 4
        beat(16'h0320, 4'd3);
        i_sample_valid = 1'b1;
        i_sample_data  = 16'hDEAD;
        i_enable       = 1'b0;
        #1;
        chk("t5_drop_ready", {31'd0, o_sample_ready}, 32'd0);
        tick();
        i_sample_valid = 1'b0;
        chk("t5_idle_ready", {31'd0, o_sample_ready}, 32'd0);
        tick();
        i_enable = 1'b1;
        tick();
        chk("t5_reen_hreq", {31'd0, o_half_req}, 32'd1);
        beat(16'h0330, 4'd0);
        i_sample_valid = 1'b0;
        tick();
        beat(16'h0331, 4'd1);
        i_sample_valid = 1'b0;
        tick();

        // 6: last beat coincides with reader edge
        for (int i = 2; i < 7; i++) beat(16'h0340 + 16'(i), 4'(i));
        i_ram_isr = 1'b0;
        beat(16'h0347, 4'd7);
        i_sample_valid = 1'b0;
        chk("t6_unrun", {31'd0, o_underrun}, 32'd1);
        chk("t6_hreq", {31'd0, o_half_req}, 32'd1);
        chk("t6_fill_ready", {31'd0, o_sample_ready}, 32'd1);
        beat(16'h0350, 4'd8);
        i_sample_valid = 1'b0;
        tick();
        tick();
        chk("t6_hold_addr", {28'd0, o_wr_address}, 32'd8);
        chk("t6_hold_data", {16'd0, o_wr_data}, 32'h0350);
        chk("t6_wren_low", {31'd0, o_wr_en}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);
        chk("hreq_total", hreq_cnt, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
